// File: rtl/csr_access_sequencer.sv
// Arbitrates CSR read-modify-write requests from several requesters onto a
// single-read / single-write CSR data port as a fixed READ -> WRITE -> RESP sequence.
module csr_access_sequencer #(
    parameter int unsigned NUM_REQS   = 2,
    parameter int unsigned ADDR_BITS  = 12,
    parameter int unsigned WID_BITS   = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid,
    output logic [NUM_REQS-1:0]              req_ready,
    input  logic [2*NUM_REQS-1:0]            req_op,
    input  logic [ADDR_BITS*NUM_REQS-1:0]    req_addr,
    input  logic [WID_BITS*NUM_REQS-1:0]     req_wid,
    input  logic [DATA_WIDTH*NUM_REQS-1:0]   req_data,
    output logic [NUM_REQS-1:0]              rsp_valid,
    input  logic [NUM_REQS-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_data,
    output logic                             read_enable,
    output logic [ADDR_BITS-1:0]             read_addr,
    output logic [WID_BITS-1:0]              read_wid,
    input  logic [DATA_WIDTH-1:0]            read_data,
    output logic                             write_enable,
    output logic [ADDR_BITS-1:0]             write_addr,
    output logic [WID_BITS-1:0]              write_wid,
    output logic [DATA_WIDTH-1:0]            write_data,
    output logic                             idle
);

    localparam int unsigned PTR_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    localparam logic [1:0] OP_RW = 2'b00;
    localparam logic [1:0] OP_RS = 2'b01;
    localparam logic [1:0] OP_RC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]            op;
        logic [ADDR_BITS-1:0]  addr;
        logic [WID_BITS-1:0]   wid;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    req_t                   req_q, req_d;
    logic [DATA_WIDTH-1:0]  old_q, old_d;

    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    req_t                   sel_req;

    // Round-robin pick: lowest valid index at or above ptr, else lowest valid overall.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (!grant_found && req_valid[i] && (PTR_W'(i) >= ptr_q)) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (!grant_found && req_valid[i]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(i);
            end
        end
    end

    // Payload of the granted requester.
    always_comb begin
        sel_req = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (PTR_W'(i) == grant_idx) begin
                sel_req.op   = req_op[2*i +: 2];
                sel_req.addr = req_addr[ADDR_BITS*i +: ADDR_BITS];
                sel_req.wid  = req_wid[WID_BITS*i +: WID_BITS];
                sel_req.data = req_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            req_q   <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            req_q   <= req_d;
            old_q   <= old_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        req_d        = req_q;
        old_d        = old_q;
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_data     = old_q;
        read_enable  = 1'b0;
        read_addr    = req_q.addr;
        read_wid     = req_q.wid;
        write_enable = 1'b0;
        write_addr   = req_q.addr;
        write_wid    = req_q.wid;
        write_data   = req_q.data;
        idle         = (state_q == ST_IDLE);

        case (state_q)
            ST_IDLE: begin
                if (grant_found && !reset) begin
                    req_ready[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    req_d   = sel_req;
                    ptr_d   = (grant_idx == PTR_W'(NUM_REQS - 1)) ? '0 : grant_idx + PTR_W'(1);
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                read_enable = 1'b1;
                old_d       = read_data;
                state_d     = ST_WRITE;
            end
            ST_WRITE: begin
                // Set/clear with an all-zero mask leaves the CSR untouched.
                case (req_q.op)
                    OP_RW: begin
                        write_data   = req_q.data;
                        write_enable = 1'b1;
                    end
                    OP_RS: begin
                        write_data   = old_q | req_q.data;
                        write_enable = |req_q.data;
                    end
                    OP_RC: begin
                        write_data   = old_q & ~req_q.data;
                        write_enable = |req_q.data;
                    end
                    default: begin
                        write_data   = '0;
                        write_enable = 1'b0;
                    end
                endcase
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
